// File: rtl/hbm_chan_router.sv
// hbm_chan_router: address-channel router in front of the HBM controller ports.
// Decodes each AR/AW request to a channel, either through a rule map or by address-bit
// interleaving. It keeps per-ID outstanding counters so that one ID never has requests
// in flight on two channels at once. The routed request is held in a single output
// register, which gives 1-cycle latency and full throughput.
module hbm_chan_router #(
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned NumRules        = 2,
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned IdWidth         = 5,
  parameter int unsigned MaxTxnsPerId    = 8,
  parameter int unsigned InterleaveMode  = 0,
  parameter int unsigned InterleaveShift = 12,
  parameter int unsigned ChanW           = $clog2(NumChannels)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumRules*(32+2*AddrWidth)-1:0]  rules_i,
  input  logic                                  slv_valid_i,
  output logic                                  slv_ready_o,
  input  logic [AddrWidth-1:0]                  slv_addr_i,
  input  logic [IdWidth-1:0]                    slv_id_i,
  output logic                                  mst_valid_o,
  input  logic                                  mst_ready_i,
  output logic [AddrWidth-1:0]                  mst_addr_o,
  output logic [IdWidth-1:0]                    mst_id_o,
  output logic [ChanW-1:0]                      mst_chan_o,
  output logic                                  mst_decerr_o,
  input  logic                                  cmpl_valid_i,
  input  logic [IdWidth-1:0]                    cmpl_id_i,
  output logic                                  cmpl_err_o
);

  localparam int unsigned RuleW  = 32 + 2 * AddrWidth;
  localparam int unsigned NumIds = 2 ** IdWidth;
  localparam int unsigned CntW   = $clog2(MaxTxnsPerId + 1);

  // Remove the channel-select bits from an interleaved address; the upper part slides down.
  function automatic logic [AddrWidth-1:0] squeeze_addr(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] lo_mask;
    lo_mask = (AddrWidth'(1) << InterleaveShift) - AddrWidth'(1);
    return ((a >> (InterleaveShift + ChanW)) << InterleaveShift) | (a & lo_mask);
  endfunction

  logic [CntW-1:0]      cnt_q [NumIds];
  logic [ChanW-1:0]     ch_q  [NumIds];
  logic                 cmpl_err_q;

  logic                 vld_p1;
  logic [AddrWidth-1:0] addr_p1;
  logic [IdWidth-1:0]   id_p1;
  logic [ChanW-1:0]     chan_p1;
  logic                 decerr_p1;

  logic [ChanW-1:0]     dec_chan;
  logic                 dec_err;
  logic [AddrWidth-1:0] dec_addr;
  logic                 hit;
  logic [31:0]          hit_idx;
  logic [CntW-1:0]      cur_cnt;
  logic [ChanW-1:0]     cur_ch;
  logic                 stall;
  logic                 accept;
  logic [NumIds-1:0]    inc_vec;
  logic [NumIds-1:0]    dec_vec;

  // Decode the incoming address into channel, error flag and outgoing address.
  always_comb begin
    dec_chan = '0;
    dec_err  = 1'b0;
    dec_addr = slv_addr_i;
    hit      = 1'b0;
    hit_idx  = '0;
    if (InterleaveMode != 0) begin
      dec_chan = slv_addr_i[InterleaveShift +: ChanW];
      dec_addr = squeeze_addr(slv_addr_i);
    end else begin
      // Walk from the highest rule down so the lowest-index hit is the last one written.
      for (int r = int'(NumRules) - 1; r >= 0; r--) begin
        if ((rules_i[r*RuleW + AddrWidth +: AddrWidth] <= slv_addr_i) &&
            (slv_addr_i < rules_i[r*RuleW +: AddrWidth])) begin
          hit     = 1'b1;
          hit_idx = rules_i[r*RuleW + 2*AddrWidth +: 32];
        end
      end
      if (!hit || (hit_idx >= NumChannels)) begin
        dec_err = 1'b1;
      end else begin
        dec_chan = hit_idx[ChanW-1:0];
      end
    end
  end

  // Per-ID ordering stall and request handshake; the stall uses the pre-update count.
  always_comb begin
    cur_cnt = cnt_q[slv_id_i];
    cur_ch  = ch_q[slv_id_i];
    if (dec_err) begin
      stall = (cur_cnt != '0);
    end else begin
      stall = (cur_cnt == CntW'(MaxTxnsPerId)) ||
              ((cur_cnt != '0) && (cur_ch != dec_chan));
    end
    slv_ready_o = (!vld_p1 || mst_ready_i) && !stall && rst_ni;
    accept      = slv_valid_i && slv_ready_o;
  end

  // Per-ID increment on a counted accept, decrement on a completion with a nonzero count.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < int'(NumIds); i++) begin
      inc_vec[i] = accept && !dec_err && (slv_id_i == IdWidth'(i));
      dec_vec[i] = cmpl_valid_i && (cmpl_id_i == IdWidth'(i)) && (cnt_q[i] != '0);
    end
  end

  // Outstanding counters and last-used channel per ID; a simultaneous inc/dec cancels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumIds); i++) begin
        cnt_q[i] <= '0;
        ch_q[i]  <= '0;
      end
      cmpl_err_q <= 1'b0;
    end else begin
      cmpl_err_q <= cmpl_valid_i && (cnt_q[cmpl_id_i] == '0);
      for (int i = 0; i < int'(NumIds); i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
        end
        if (inc_vec[i]) begin
          ch_q[i] <= dec_chan;
        end
      end
    end
  end

  // ---- stage p1: routed request register, held until the downstream handshake ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      id_p1     <= '0;
      chan_p1   <= '0;
      decerr_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      addr_p1   <= dec_addr;
      id_p1     <= slv_id_i;
      chan_p1   <= dec_chan;
      decerr_p1 <= dec_err;
    end else if (mst_ready_i) begin
      vld_p1    <= 1'b0;
    end
  end

  assign mst_valid_o  = vld_p1;
  assign mst_addr_o   = addr_p1;
  assign mst_id_o     = id_p1;
  assign mst_chan_o   = chan_p1;
  assign mst_decerr_o = decerr_p1;
  assign cmpl_err_o   = cmpl_err_q;

endmodule
